seg7_scroll_display: RTL and testbench
======================================

# seg7_scroll_display

Multi-digit seven-segment display controller with a character queue and a per-character "draw-in" animation. Hex nibbles are pushed in through a valid/ready handshake and buffered in a FIFO. Each character scrolls in at the rightmost digit, and its segments light one per animation frame. The block time-multiplexes `NUM_DIGITS` digits onto one shared segment bus and sits between the top-level input pins and `uo_out`. It replaces the single-digit animated hex path.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of multiplexed digits (2..8).
- `FIFO_DEPTH`, default 4: character queue depth; must be a power of 2 and at least 2.
- `TICK_DIV`, default 200000: clock cycles per animation frame; must be at least 2.
- `SCAN_DIV`, default 1000: clock cycles each digit stays selected; must be at least 1.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `char_valid`, in, 1: a character is offered.
- `char_data`, in, 4: hex nibble 0x0..0xF.
- `char_ready`, out, 1: FIFO can accept; equals `!full`.
- `mode`, in, 1: 0 = animated draw-in, 1 = instant; sampled at pop.
- `seg`, out, 7: segments, active-high, bit0 = a … bit6 = g.
- `digit_sel`, out, `NUM_DIGITS`: one-hot digit enable, active-high; bit0 = rightmost digit.
- `busy`, out, 1: high while in state DRAW.

## Operation
- **FIFO handshake**
  - A push occurs when `char_valid && char_ready`.
  - A pop occurs in IDLE when the FIFO is not empty.
  - Push and pop in the same cycle leave the count unchanged.
  - `full` and `empty` are registered count flags.
  - A push is never accepted while full, even if a pop happens in that cycle.
- **Digit store**: `NUM_DIGITS` entries of {`valid`, `nibble[3:0]`}. An entry with `valid` = 0 shows blank (`seg` = 0).
- **On pop**
  - Shift the store: entry[i] takes entry[i-1] for i ≥ 1, and entry[NUM_DIGITS-1] is discarded.
  - Entry[0] takes {1, popped nibble}.
- **State machine**: states IDLE and DRAW.
  - IDLE with the FIFO non-empty: pop.
    - If `mode` = 0: set `mask` = 7'h00, clear the frame counter, and go to DRAW.
    - If `mode` = 1: set `mask` = 7'h7F and stay in IDLE. Back-to-back pops can then occur every cycle.
  - DRAW: the frame counter counts 0..TICK_DIV-1.
    - At count TICK_DIV-1, set the lowest clear bit of `mask` (order a, b, c, d, e, f, g) and reset the counter to 0.
    - When the update makes `mask` = 7'h7F, go to IDLE.
- **Hex decode** (g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- **Scan**
  - `scan_idx` advances every SCAN_DIV cycles and wraps from NUM_DIGITS-1 to 0.
  - `digit_sel` = one-hot(`scan_idx`), registered.
- **Segment output**
  - `seg` = decode(entry[`scan_idx`]) when valid, else 0, ANDed with `mask` when `scan_idx` = 0.
  - Digits other than digit 0 are never masked.
  - `seg` is combinational from registered state only.
- **Reset** (the synchronous reset takes priority over all other activity)
  - State IDLE; FIFO empty; all entries invalid.
  - `mask` = 7'h7F; counters 0; `scan_idx` = 0.
  - Resulting outputs: `seg` = 0, `digit_sel` = 1, `busy` = 0, `char_ready` = 1.
  - A reset mid-DRAW discards the animation and the queued characters.

## Timing
- **Push to pop**: a push at edge N makes the FIFO non-empty at N+1. The pop and store shift happen at edge N+1 when the block is in IDLE.
- **Animated draw (`mode` = 0)**
  - DRAW is entered at the pop edge.
  - Mask bit k sets (k+1)·TICK_DIV edges after the pop.
  - Return to IDLE happens at the 7th update, 7·TICK_DIV edges after the pop.
  - The next pop happens one edge later.
- **Instant (`mode` = 1)**: the character is fully visible the cycle after the pop. Sustained throughput is one character per cycle.
- **`busy`**: asserted from the pop edge through the last DRAW cycle.
- **Scan period**: NUM_DIGITS·SCAN_DIV cycles. Scan runs independently of the state machine and never stalls.
- **`char_ready` after a filling push**: deasserts the cycle after the push that makes count = FIFO_DEPTH.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, FIFO_DEPTH=4, TICK_DIV=4, SCAN_DIV=2.

1. **Reset state**: hold `reset` for 2 cycles → `seg`=00, `digit_sel`=0001, `busy`=0, `char_ready`=1. Over the next 8 cycles `digit_sel` cycles 0001→0010→0100→1000→0001, changing every 2 cycles, with `seg`=00 throughout.
2. **Animated 'A'**: push 0xA with `mode`=0. While `digit_sel`=0001, `seg` steps 00→01→03→07→07→17→37→77, one step per 4 cycles. `busy` is high for exactly 28 cycles after the pop.
3. **Instant scroll**: push 1, 2, 3, 4, 5 back-to-back with `mode`=1 → digits 3..0 show 2, 3, 4, 5 (`seg` 5B, 4F, 66, 6D). `busy` stays 0 throughout.
4. **Backpressure**: with `mode`=0, offer 6 characters on consecutive cycles.
   - The first is popped and the next four fill the FIFO.
   - `char_ready`=0 and the 6th is held.
   - The 6th is accepted on the cycle after the pop that follows the first animation completing.
5. **Reset mid-animation**: assert `reset` at cycle 10 of a DRAW with the FIFO holding 2 entries → the next cycle shows the reset state and no further characters appear.
6. **Simultaneous push and pop**: with 1 entry queued in IDLE, push in the same cycle as the pop → count stays 1 and the characters appear in push order.

Source files
------------

// File: rtl/seg7_scroll_display.sv
// Multiplexed seven-segment display with a character FIFO. Each popped nibble scrolls in at
// digit 0 and either appears at once or is drawn in one segment per animation frame.
module seg7_scroll_display #(
    parameter int NUM_DIGITS = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 200000,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  char_valid,
    input  logic [3:0]            char_data,
    output logic                  char_ready,
    input  logic                  mode,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [6:0]            MASK_FULL = 7'h7F;
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

    typedef enum logic {
        S_IDLE,
        S_DRAW
    } state_e;

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    logic [3:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push;
    logic             pop;

    // A pop frees a slot only on the following cycle; the registered full flag gates the push.
    assign push       = char_valid && !full_q;
    assign char_ready = !full_q;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // NOTE: the storage array carries no reset; the pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= char_data;
        end
    end

    // ------------------------------------------------------------------
    // Draw-in state machine
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [6:0]        mask_q, mask_d;
    logic [TICK_W-1:0] tick_q, tick_d;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        tick_d  = tick_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop = 1'b1;
                    if (mode) begin
                        mask_d = MASK_FULL;
                    end else begin
                        mask_d  = 7'h00;
                        tick_d  = '0;
                        state_d = S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    // Adding one ripples into the lowest clear bit; OR keeps the bits below it set.
                    mask_d = mask_q | (mask_q + 7'd1);
                    if (mask_d == MASK_FULL) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_DRAW);

    // ------------------------------------------------------------------
    // Digit store (entry 0 is the rightmost digit)
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] ent_valid_q, ent_valid_d;
    logic [3:0]            ent_nib_q [NUM_DIGITS];
    logic [3:0]            ent_nib_d [NUM_DIGITS];

    always_comb begin
        ent_valid_d = ent_valid_q;
        ent_nib_d   = ent_nib_q;
        if (pop) begin
            ent_valid_d = {ent_valid_q[NUM_DIGITS-2:0], 1'b1};
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                ent_nib_d[i] = ent_nib_q[i-1];
            end
            ent_nib_d[0] = fifo_mem[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
        // Derived from the next index so the registered select stays aligned with scan_idx_q.
        digit_sel_d = SEL_ONE << scan_idx_d;
    end

    assign digit_sel = digit_sel_q;

    // ------------------------------------------------------------------
    // Segment output
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    logic [6:0] seg_raw;

    always_comb begin
        seg_raw = ent_valid_q[scan_idx_q] ? hex_decode(ent_nib_q[scan_idx_q]) : 7'h00;
        seg     = (scan_idx_q == '0) ? (seg_raw & mask_q) : seg_raw;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            state_q     <= S_IDLE;
            mask_q      <= MASK_FULL;
            tick_q      <= '0;
            ent_valid_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                ent_nib_q[i] <= 4'h0;
            end
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            digit_sel_q <= SEL_ONE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            state_q     <= state_d;
            mask_q      <= mask_d;
            tick_q      <= tick_d;
            ent_valid_q <= ent_valid_d;
            ent_nib_q   <= ent_nib_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            digit_sel_q <= digit_sel_d;
        end
    end

endmodule

// File: tb/tb_seg7_scroll_display.sv
// Bench for seg7_scroll_display: directed scenarios plus random traffic, all compared against
// an event-level model (character queue, digit list, arithmetic frame and scan timing).
module tb_seg7_scroll_display;

    localparam int ND = 4;
    localparam int FD = 4;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam int DRAW_LEN = 7 * TD;

    logic          clk = 1'b0;
    logic          reset;
    logic          char_valid;
    logic [3:0]    char_data;
    logic          char_ready;
    logic          mode;
    logic [6:0]    seg;
    logic [ND-1:0] digit_sel;
    logic          busy;

    int passed = 0;
    int total  = 0;

    seg7_scroll_display #(
        .NUM_DIGITS(ND),
        .FIFO_DEPTH(FD),
        .TICK_DIV  (TD),
        .SCAN_DIV  (SD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_ready(char_ready),
        .mode      (mode),
        .seg       (seg),
        .digit_sel (digit_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int q[$];
    int dig[ND];
    int e_cnt  = 0;
    int rst_e  = 0;
    int pop_e  = 0;
    bit anim   = 1'b0;
    bit m_push = 1'b0;

    logic [6:0]    exp_seg;
    logic [ND-1:0] exp_sel;
    logic          exp_busy;
    logic          exp_ready;
    int            exp_idx;

    task automatic model_edge(input bit v, input logic [3:0] d, input bit m, input bit r);
        bit         idle;
        bit         pop_ok;
        int         frames;
        logic [6:0] mask;
        e_cnt++;
        m_push = 1'b0;
        if (r) begin
            q.delete();
            for (int i = 0; i < ND; i++) dig[i] = -1;
            anim  = 1'b0;
            rst_e = e_cnt;
        end else begin
            idle   = !(anim && (e_cnt - 1 - pop_e) < DRAW_LEN);
            pop_ok = idle && (q.size() > 0);
            m_push = v && (q.size() < FD);
            if (pop_ok) begin
                for (int i = ND - 1; i > 0; i--) dig[i] = dig[i-1];
                dig[0] = q.pop_front();
                anim   = !m;
                pop_e  = e_cnt;
            end
            if (m_push) q.push_back(int'(d));
        end
        exp_idx   = ((e_cnt - rst_e) / SD) % ND;
        frames    = anim ? (e_cnt - pop_e) / TD : 7;
        if (frames > 7) frames = 7;
        mask      = 7'((1 << frames) - 1);
        exp_busy  = anim && ((e_cnt - pop_e) < DRAW_LEN);
        exp_ready = (q.size() < FD);
        exp_sel   = ND'(1 << exp_idx);
        if (dig[exp_idx] < 0) exp_seg = 7'h00;
        else exp_seg = seg_tbl[dig[exp_idx]] & ((exp_idx == 0) ? mask : 7'h7F);
    endtask

    // Drive inputs mid-cycle, advance one rising edge, update the model, sample 1 ns later.
    task automatic step(input bit v, input logic [3:0] d, input bit m, input bit r);
        char_valid = v;
        char_data  = d;
        mode       = m;
        reset      = r;
        @(posedge clk);
        model_edge(v, d, m, r);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] sel_tbl [8] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                    4'b0100, 4'b1000, 4'b1000, 4'b0001};
        step(0, 4'h0, 0, 1);
        step(0, 4'h0, 0, 1);
        total++; if (seg !== 7'h00) $display("FAIL reset_seg: got %h expected 00", seg); else passed++;
        total++; if (digit_sel !== 4'b0001) $display("FAIL reset_sel: got %b expected 0001", digit_sel); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (char_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", char_ready); else passed++;
        for (int k = 0; k < 8; k++) begin
            step(0, 4'h0, 0, 0);
            total++;
            if (digit_sel !== sel_tbl[k])
                $display("FAIL reset_scan k=%0d: got %b expected %b", k, digit_sel, sel_tbl[k]);
            else passed++;
            total++; if (seg !== 7'h00) $display("FAIL reset_blank k=%0d: got %h expected 00", k, seg); else passed++;
        end
    endtask

    task automatic test_animated();
        logic [6:0] anim_tbl [8] = '{7'h00, 7'h01, 7'h03, 7'h07, 7'h07, 7'h17, 7'h37, 7'h77};
        int busy_cnt = 0;
        int fr;
        step(1, 4'hA, 0, 0);
        for (int k = 0; k < 34; k++) begin
            step(0, 4'h0, 0, 0);
            if (busy === 1'b1) busy_cnt++;
            if (k == 0) begin
                total++; if (busy !== 1'b1) $display("FAIL anim_busy_start: got %b expected 1", busy); else passed++;
            end
            total++;
            if (seg !== exp_seg) $display("FAIL anim_seg k=%0d: got %h expected %h", k, seg, exp_seg);
            else passed++;
            if (exp_idx == 0) begin
                fr = k / TD;
                if (fr > 7) fr = 7;
                total++;
                if (seg !== anim_tbl[fr]) $display("FAIL anim_frame k=%0d: got %h expected %h", k, seg, anim_tbl[fr]);
                else passed++;
            end
        end
        total++; if (busy_cnt != DRAW_LEN) $display("FAIL anim_busy_len: got %0d expected %0d", busy_cnt, DRAW_LEN); else passed++;
    endtask

    task automatic test_instant();
        logic [6:0] by_idx [4] = '{7'h6D, 7'h66, 7'h4F, 7'h5B};
        step(0, 4'h0, 1, 1);
        for (int k = 1; k <= 7; k++) begin
            step(k <= 5, 4'(k), 1, 0);
            total++; if (busy !== 1'b0) $display("FAIL inst_busy k=%0d: got %b expected 0", k, busy); else passed++;
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 4'h0, 1, 0);
            total++;
            if (seg !== by_idx[exp_idx]) $display("FAIL inst_digit idx=%0d: got %h expected %h", exp_idx, seg, by_idx[exp_idx]);
            else passed++;
            total++; if (digit_sel !== exp_sel) $display("FAIL inst_sel: got %b expected %b", digit_sel, exp_sel); else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] vals [6] = '{4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC};
        bit accepted = 1'b0;
        bit rdy_before;
        int acc_k = -1;
        step(0, 4'h0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, vals[i], 0, 0);
        total++; if (char_ready !== 1'b0) $display("FAIL bp_full: got %b expected 0", char_ready); else passed++;
        for (int k = 0; k < 60 && !accepted; k++) begin
            rdy_before = char_ready;
            step(1, vals[5], 0, 0);
            if (rdy_before === 1'b1) begin
                accepted = 1'b1;
                acc_k    = k;
            end
            total++;
            if (char_ready !== exp_ready) $display("FAIL bp_ready k=%0d: got %b expected %b", k, char_ready, exp_ready);
            else passed++;
        end
        total++; if (!accepted) $display("FAIL bp_timeout: got no accept expected accept within 60 cycles"); else passed++;
        total++; if (acc_k != 26) $display("FAIL bp_accept_cycle: got %0d expected 26", acc_k); else passed++;
    endtask

    task automatic test_reset_mid();
        step(0, 4'h0, 0, 1);
        step(1, 4'h1, 0, 0);
        step(1, 4'h2, 0, 0);
        step(1, 4'h3, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 4'h0, 0, 0);
        total++; if (busy !== 1'b1) $display("FAIL rmid_drawing: got %b expected 1", busy); else passed++;
        step(0, 4'h0, 0, 1);
        total++; if (seg !== 7'h00) $display("FAIL rmid_seg: got %h expected 00", seg); else passed++;
        total++; if (digit_sel !== 4'b0001) $display("FAIL rmid_sel: got %b expected 0001", digit_sel); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", busy); else passed++;
        total++; if (char_ready !== 1'b1) $display("FAIL rmid_ready: got %b expected 1", char_ready); else passed++;
        for (int k = 0; k < 40; k++) begin
            step(0, 4'h0, 0, 0);
            total++;
            if (seg !== 7'h00 || busy !== 1'b0)
                $display("FAIL rmid_quiet k=%0d: got seg=%h busy=%b expected seg=00 busy=0", k, seg, busy);
            else passed++;
        end
    endtask

    task automatic test_simultaneous();
        logic [6:0] by_idx [4] = '{7'h71, 7'h07, 7'h3F, 7'h5E};
        step(0, 4'h0, 0, 1);
        step(1, 4'hE, 0, 0);
        step(1, 4'hD, 0, 0);
        step(1, 4'h0, 0, 0);
        step(1, 4'h7, 0, 0);
        total++; if (char_ready !== 1'b1) $display("FAIL simul_count3: got %b expected 1", char_ready); else passed++;
        step(1, 4'hF, 0, 0);
        total++; if (char_ready !== 1'b0) $display("FAIL simul_count4: got %b expected 0", char_ready); else passed++;
        for (int k = 0; k < 40; k++) step(0, 4'h0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 4'h0, 1, 0);
            total++;
            if (seg !== by_idx[exp_idx]) $display("FAIL simul_order idx=%0d: got %h expected %h", exp_idx, seg, by_idx[exp_idx]);
            else passed++;
        end
    endtask

    task automatic test_random();
        bit         v;
        bit         m;
        bit         r;
        logic [3:0] d;
        step(0, 4'h0, 1, 1);
        for (int c = 0; c < 800; c++) begin
            v = ($urandom_range(1, 0) == 1);
            m = ($urandom_range(3, 0) != 0);
            r = ($urandom_range(149, 0) == 0);
            d = 4'($urandom_range(15, 0));
            step(v, d, m, r);
            total++; if (seg !== exp_seg) $display("FAIL rand_seg c=%0d: got %h expected %h", c, seg, exp_seg); else passed++;
            total++; if (digit_sel !== exp_sel) $display("FAIL rand_sel c=%0d: got %b expected %b", c, digit_sel, exp_sel); else passed++;
            total++; if (busy !== exp_busy) $display("FAIL rand_busy c=%0d: got %b expected %b", c, busy, exp_busy); else passed++;
            total++; if (char_ready !== exp_ready) $display("FAIL rand_ready c=%0d: got %b expected %b", c, char_ready, exp_ready); else passed++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_data  = 4'h0;
        mode       = 1'b0;
        test_reset();
        test_animated();
        test_instant();
        test_backpressure();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
